serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in.
REQ-008 The block SHALL have port diff, output, WIDTH bits: registered result a - b - bin, modulo 2^WIDTH.
REQ-009 The block SHALL have port bout, output, 1 bit: registered borrow-out, 1 when a < b + bin as unsigned values.
REQ-010 The block SHALL have port ovf, output, 1 bit: registered two's-complement overflow flag.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 at edge E0, the block SHALL latch a, b and bin into internal registers, clear the bit counter and enter RUN; start=0 SHALL leave it in IDLE.
REQ-015 In RUN, each edge SHALL process one bit, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (b_i & br) | (~a_i & br).
REQ-016 Each computed d bit SHALL be shifted into an internal result shift register, and the counter SHALL increment.
REQ-017 Bit i SHALL be processed at edge E(i+1); at edge E(WIDTH), after the MSB is processed, the FSM SHALL enter DONE.
REQ-018 At edge E(WIDTH), diff, bout and ovf SHALL be loaded from the completed result.
REQ-019 Latency: done SHALL be high exactly in the cycle between E(WIDTH) and E(WIDTH+1), for exactly one cycle.
REQ-020 DONE SHALL always return to IDLE on the next edge.
REQ-021 ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands.
REQ-022 diff, bout and ovf SHALL change only at completion edges and SHALL hold their values through the following IDLE cycles and any subsequent RUN, until the next completion.
REQ-023 start SHALL be ignored in RUN and DONE; it is not queued.
REQ-024 A new start in the first IDLE cycle after DONE SHALL be accepted, giving a back-to-back throughput of one result per WIDTH+2 cycles.
REQ-025 Changes on a, b or bin after the E0 latch SHALL NOT affect the operation in progress.
REQ-026 busy SHALL be high exactly in RUN.
REQ-027 busy and done SHALL never be high in the same cycle.

Reset
REQ-028 While rst=1, regardless of clk, the FSM SHALL be in IDLE.
REQ-029 While rst=1, diff, bout, ovf, busy and done SHALL all be 0, and the counter, borrow and shift registers SHALL be cleared.
REQ-030 Reset asserted during RUN SHALL abort the operation, produce no done pulse, and leave the previous results cleared to 0.
REQ-031 After rst deasserts, the first start SHALL be accepted at the first rising edge at which rst=0.

Verification (WIDTH=8)
REQ-032 Basic: a=0x05, b=0x03, bin=0, start pulse -> done exactly 8 edges after the latch edge; diff=0x02, bout=0, ovf=0; busy high for 8 cycles.
REQ-033 Borrow/wrap: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-034 Signed overflow: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
REQ-035 Ignore and hold: pulse start and change a/b every cycle during RUN -> the result reflects only the latched operands, there is exactly one done pulse, and outputs hold afterwards.
REQ-036 Reset mid-operation: assert rst at edge E3 of a run -> outputs immediately 0, no done pulse. After release, a new start with a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1, ovf=0.
REQ-037 Exhaustive sweep: all a, b, bin combinations, run back-to-back -> every result matches a - b - bin with correct bout/ovf, at one result per 10 cycles.

Source files
------------

// File: rtl/serial_sub.sv
// ============================================================================
// serial_sub : bit-serial subtractor, LSB first, computes a - b - bin
// Revision   : 1.0
// ============================================================================
`default_nettype none

module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int             CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             d_bit;
   logic             br_nx;
   logic [WIDTH-1:0] res_nx;

   // One full-subtractor slice; operands shift right so bit 0 is always current
   assign d_bit  = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
   assign br_nx  = (~a_sh_q[0] & b_sh_q[0]) | (b_sh_q[0] & br_q) | (~a_sh_q[0] & br_q);
   assign res_nx = {d_bit, res_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
               br_d    = bin;
               cnt_d   = '0;
               res_d   = '0;
               state_d = S_RUN;
               busy_d  = 1'b1;
            end
         end
         S_RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = br_nx;
            res_d  = res_nx;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == C_LAST) begin
               // MSB slice: publish the finished result in the same edge
               state_d = S_DONE;
               done_d  = 1'b1;
               diff_d  = res_nx;
               bout_d  = br_nx;
               ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
            end else begin
               busy_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
// ============================================================================
// tb_serial_sub : randomized + directed bench for serial_sub (WIDTH = 8)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_serial_sub;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;
   logic         busy;
   logic         done;

   int n_cmp = 0;
   int n_err = 0;

   serial_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: timeline of one operation, measured in clock edges
   logic [W-1:0] m_diff = '0;
   logic         m_bout = 1'b0;
   logic         m_ovf  = 1'b0;
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic [W-1:0] p_diff = '0;
   logic         p_bout = 1'b0;
   logic         p_ovf  = 1'b0;
   bit           m_act  = 1'b0;
   int           m_edge = 0;
   int           m_acc  = 0;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_act  = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_diff = '0;
            m_bout = 1'b0;
            m_ovf  = 1'b0;
            m_edge = 0;
         end else begin
            bit was;
            int tmp;
            m_edge++;
            was    = m_act;
            m_done = 1'b0;
            if (m_act && m_edge == m_acc + W) begin
               m_diff = p_diff;
               m_bout = p_bout;
               m_ovf  = p_ovf;
               m_done = 1'b1;
            end
            if (m_act && m_edge == m_acc + W + 1) m_act = 1'b0;
            if (!was && start) begin
               m_act  = 1'b1;
               m_acc  = m_edge;
               tmp    = int'(a) - int'(b) - int'(bin);
               p_diff = tmp[W-1:0];
               p_bout = (tmp < 0);
               p_ovf  = (a[W-1] != b[W-1]) && (p_diff[W-1] != a[W-1]);
            end
            m_busy = m_act && (m_edge < m_acc + W);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("busy", {31'd0, busy}, {31'd0, m_busy});
         chk("done", {31'd0, done}, {31'd0, m_done});
         chk("diff", {24'd0, diff}, {24'd0, m_diff});
         chk("bout", {31'd0, bout}, {31'd0, m_bout});
         chk("ovf",  {31'd0, ovf},  {31'd0, m_ovf});
      end
   end

   // Directed operation with literal expectations, including done latency
   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
      int  n;
      bit  seen;
      n    = 0;
      seen = 1'b0;
      @(negedge clk);
      a     = ia;
      b     = ib;
      bin   = ibin;
      start = 1'b1;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) begin
            seen = 1'b1;
            n    = i;
         end
      end
      chk("op_latency", n, 9);
      chk("op_diff", {24'd0, diff}, {24'd0, ed});
      chk("op_bout", {31'd0, bout}, {31'd0, eb});
      chk("op_ovf",  {31'd0, ovf},  {31'd0, eo});
   endtask

   logic [W-1:0] edge_vals [6] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};

   initial begin
      int dones;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_diff", {24'd0, diff}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      rst = 1'b0;

      run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

      // start and operands churn during RUN; only the latched op counts
      @(negedge clk);
      a     = 8'h33;
      b     = 8'h11;
      bin   = 1'b0;
      start = 1'b1;
      dones = 0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
         if (i <= 7) begin
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      chk("ign_dones", dones, 1);
      chk("ign_diff", {24'd0, diff}, 32'h22);

      // reset at edge E3 of a run
      @(negedge clk);
      a     = 8'h44;
      b     = 8'h12;
      bin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_diff", {24'd0, diff}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

      // boundary operands, back-to-back at one result per W+2 cycles
      foreach (edge_vals[i]) begin
         foreach (edge_vals[j]) begin
            for (int k = 0; k < 2; k++) begin
               @(negedge clk);
               a     = edge_vals[i];
               b     = edge_vals[j];
               bin   = k[0];
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
               repeat (W) @(negedge clk);
            end
         end
      end

      // free-running random traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         a     = W'($urandom);
         b     = W'($urandom);
         bin   = 1'($urandom);
         start = ($urandom_range(0, 3) != 0);
      end
      start = 1'b0;
      repeat (W + 4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
